sprite_layer_mixer: RTL
=======================

// Module: sprite_layer_mixer
// PURPOSE
//  Parametrised, pipelined sprite compositor for the VGA pixel path; generalises the pacman/ghost/item drawing.
//  Per-pixel: hit-tests NUM_SPR square sprites, issues per-channel sprite-ROM addresses, waits ROM_LAT,
//  then overlays the opaque sprite pixels (key colour = transparent) on a caller-supplied background colour.
//  Adds a flash/hide mode and sticky sprite-0 collision detection. Feeds the VGA RGB outputs.
// PARAMETERS
//  NUM_SPR   4         number of sprite channels; channel 0 has the highest priority
//  SPR_W     26        sprite edge in pixels (square); one frame = SPR_W*SPR_W words
//  ADDR_W    12        sprite-ROM address width per channel
//  ROM_LAT   1         sprite-ROM read latency in cycles (>=1)
//  KEY_COLOR 24'h0     RGB value treated as transparent
//  FLASH_DIV 16        frame ticks per flash phase
// PORTS
//  Clk        in   1                   pixel clock
//  Reset      in   1                   synchronous, active-high
//  blank      in   1                   1 = active video pixel
//  DrawX      in   10                  current pixel x
//  DrawY      in   10                  current pixel y
//  bg_rgb     in   24                  background colour for the same pixel (maze/dots/text), aligned with DrawX
//  frame_tick in   1                   one-cycle pulse per video frame
//  spr_en     in   NUM_SPR             per-channel enable
//  spr_x      in   NUM_SPR x 10        sprite top-left x
//  spr_y      in   NUM_SPR x 10        sprite top-left y
//  spr_frame  in   NUM_SPR x 2         animation frame index (e.g. mouth direction)
//  flash_en   in   NUM_SPR             channel participates in flash
//  rom_addr   out  NUM_SPR x ADDR_W    registered sprite-ROM address
//  rom_data   in   NUM_SPR x 24        ROM output, valid ROM_LAT cycles after rom_addr
//  collide_clr in  1                   clears collide
//  Red, Green, Blue out 8 each         registered pixel colour
//  out_valid  out  1                   delayed blank
//  collide    out  1                   sticky: sprite 0 overlapped another opaque sprite
// BEHAVIOUR
//  - Latency L = ROM_LAT + 2 cycles from DrawX/DrawY/blank/bg_rgb to Red/Green/Blue/out_valid; fully pipelined, 1 pixel/cycle.
//  - S0 (registered): hit[i] = spr_en[i] & DrawX>=spr_x[i] & DrawX<spr_x[i]+SPR_W & same for y; sums taken
//    11 bits wide, so no wrap at x/y near 1023. rom_addr[i] = spr_frame[i]*SPR_W*SPR_W
//    + (DrawY-spr_y[i])*SPR_W + (DrawX-spr_x[i]), truncated to ADDR_W; rom_addr[i]=0 when !hit[i].
//  - hit, blank, bg_rgb delayed through a ROM_LAT-deep shift register to meet rom_data.
//  - S_out: opq[i] = hit_d[i] & rom_data[i]!=KEY_COLOR & !(flash_en[i] & flash_phase).
//    Colour = rom_data of lowest-index opq channel, else bg_rgb_d. If !blank_d, colour = 0.
//  - Flash: 5-bit-min counter counts frame_tick; on reaching FLASH_DIV-1 wraps to 0 and toggles flash_phase.
//  - collide <= 1 when blank_d & opq[0] & |opq[NUM_SPR-1:1]; else cleared by collide_clr;
//    simultaneous set and clear -> set wins.
//  - Reset: Red/Green/Blue=0, out_valid=0, rom_addr=0, collide=0, flash counter=0, flash_phase=0, all pipeline
//    valid bits 0; first valid output L cycles after first blank=1 post-reset. Reset mid-line flushes pipeline.
//  - Inputs spr_* sampled per pixel; a change mid-frame affects pixels from the next cycle (tearing allowed).
// TESTING
//  1 Reset held 3 cycles with blank=1 -> RGB=0, out_valid=0, collide=0 throughout and rom_addr=0.
//  2 spr0 at (100,100), frame 2, DrawX=105,DrawY=103 -> rom_addr[0]=2*676+3*26+5=1435 one cycle later;
//    ROM returns 24'hFFFF00 -> RGB=FF/FF/00 at cycle L.
//  3 rom_data=KEY_COLOR inside spr0 box, bg_rgb=24'h47B7AE -> RGB=47/B7/AE (transparency); outside box same.
//  4 spr0 and spr1 both opaque at (200,50) -> spr0 colour shown, collide=1 and stays; collide_clr pulse with
//    no overlap -> 0; clr concurrent with overlap -> stays 1.
//  5 flash_en[1]=1, FLASH_DIV=2: 2 frame_ticks -> spr1 hidden (bg shown), 2 more -> visible again.
//  6 spr_x=1010, DrawX=1015, and DrawX=3 -> hit only at 1015 (no wrap); blank=0 -> RGB=0, out_valid=0 after L.

Source files
------------

// File: rtl/sprite_layer_mixer.sv
// Pipelined sprite compositor: hit-tests square sprites per pixel, issues sprite-ROM
// addresses, waits out the ROM latency, then overlays opaque sprite pixels on the
// background colour. Adds per-channel flash/hide and sticky sprite-0 collision.
module sprite_layer_mixer #(
    parameter int unsigned NUM_SPR   = 4,
    parameter int unsigned SPR_W     = 26,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned ROM_LAT   = 1,
    parameter logic [23:0] KEY_COLOR = 24'h0,
    parameter int unsigned FLASH_DIV = 16
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             blank,
    input  logic [9:0]                       DrawX,
    input  logic [9:0]                       DrawY,
    input  logic [23:0]                      bg_rgb,
    input  logic                             frame_tick,
    input  logic [NUM_SPR-1:0]               spr_en,
    input  logic [NUM_SPR-1:0][9:0]          spr_x,
    input  logic [NUM_SPR-1:0][9:0]          spr_y,
    input  logic [NUM_SPR-1:0][1:0]          spr_frame,
    input  logic [NUM_SPR-1:0]               flash_en,
    output logic [NUM_SPR-1:0][ADDR_W-1:0]   rom_addr,
    input  logic [NUM_SPR-1:0][23:0]         rom_data,
    input  logic                             collide_clr,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic                             out_valid,
    output logic                             collide
);

    localparam int unsigned FlashW = ($clog2(FLASH_DIV) > 5) ? $clog2(FLASH_DIV) : 5;

    logic [NUM_SPR-1:0]               hit_d;
    logic [NUM_SPR-1:0][ADDR_W-1:0]   addr_d;

    // Delay line aligning hit/blank/bg with rom_data; the last entry meets the ROM output.
    logic [ROM_LAT-1:0][NUM_SPR-1:0]  hit_pipe_q;
    logic [ROM_LAT-1:0]               blank_pipe_q;
    logic [ROM_LAT-1:0][23:0]         bg_pipe_q;

    logic [NUM_SPR-1:0]               hit_s0_q;
    logic                             blank_s0_q;
    logic [23:0]                      bg_s0_q;

    logic [NUM_SPR-1:0]               opq;
    logic [23:0]                      pix_rgb;
    logic                             collide_d;

    logic [FlashW-1:0]                flash_cnt_q, flash_cnt_d;
    logic                             flash_phase_q, flash_phase_d;

    // Hit test and ROM address for every channel; 11-bit bounds avoid wrap near x/y=1023.
    always_comb begin
        hit_d  = '0;
        addr_d = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            hit_d[i] = spr_en[i]
                && ({1'b0, DrawX} >= {1'b0, spr_x[i]})
                && ({1'b0, DrawX} < ({1'b0, spr_x[i]} + 11'(SPR_W)))
                && ({1'b0, DrawY} >= {1'b0, spr_y[i]})
                && ({1'b0, DrawY} < ({1'b0, spr_y[i]} + 11'(SPR_W)));
            if (hit_d[i]) begin
                addr_d[i] = ADDR_W'(32'(spr_frame[i]) * 32'(SPR_W * SPR_W)
                                  + 32'(DrawY - spr_y[i]) * 32'(SPR_W)
                                  + 32'(DrawX - spr_x[i]));
            end
        end
    end

    // Stage 0 registers plus the ROM-latency delay line.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr     <= '0;
            hit_s0_q     <= '0;
            blank_s0_q   <= 1'b0;
            bg_s0_q      <= '0;
            hit_pipe_q   <= '0;
            blank_pipe_q <= '0;
            bg_pipe_q    <= '0;
        end else begin
            rom_addr        <= addr_d;
            hit_s0_q        <= hit_d;
            blank_s0_q      <= blank;
            bg_s0_q         <= bg_rgb;
            hit_pipe_q[0]   <= hit_s0_q;
            blank_pipe_q[0] <= blank_s0_q;
            bg_pipe_q[0]    <= bg_s0_q;
            for (int j = 1; j < ROM_LAT; j++) begin
                hit_pipe_q[j]   <= hit_pipe_q[j-1];
                blank_pipe_q[j] <= blank_pipe_q[j-1];
                bg_pipe_q[j]    <= bg_pipe_q[j-1];
            end
        end
    end

    // Opacity, priority mux (lowest index wins), blanking and collision next state.
    always_comb begin
        opq       = '0;
        pix_rgb   = bg_pipe_q[ROM_LAT-1];
        collide_d = collide;
        for (int i = 0; i < NUM_SPR; i++) begin
            opq[i] = hit_pipe_q[ROM_LAT-1][i] && (rom_data[i] != KEY_COLOR)
                     && !(flash_en[i] && flash_phase_q);
        end
        for (int i = int'(NUM_SPR) - 1; i >= 0; i--) begin
            if (opq[i]) pix_rgb = rom_data[i];
        end
        if (!blank_pipe_q[ROM_LAT-1]) pix_rgb = '0;
        if (collide_clr) collide_d = 1'b0;
        // Set has priority over a concurrent clear.
        if (blank_pipe_q[ROM_LAT-1] && opq[0] && (|opq[NUM_SPR-1:1])) collide_d = 1'b1;
    end

    // Flash phase toggles every FLASH_DIV frame ticks.
    always_comb begin
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        if (frame_tick) begin
            if (flash_cnt_q == FlashW'(FLASH_DIV - 1)) begin
                flash_cnt_d   = '0;
                flash_phase_d = !flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
    end

    // Output, collision and flash state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red           <= '0;
            Green         <= '0;
            Blue          <= '0;
            out_valid     <= 1'b0;
            collide       <= 1'b0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            {Red, Green, Blue} <= pix_rgb;
            out_valid          <= blank_pipe_q[ROM_LAT-1];
            collide            <= collide_d;
            flash_cnt_q        <= flash_cnt_d;
            flash_phase_q      <= flash_phase_d;
        end
    end

endmodule
